// File: rtl/ysyx_22040386_dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package ysyx_22040386_dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int   CNT_W    = 4;
    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Window test done in 65 bits so a window ending at the top of the address space cannot wrap.
    function automatic logic dm_in_window(input logic [63:0] addr, input logic [63:0] base,
                                          input int unsigned aw);
        logic [64:0] limit;
        limit = {1'b0, base} + (65'd1 << (aw + 32'd3));
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/ysyx_22040386_dmem_if.sv
// Load/store request-response bus between the MEM stage (master) and the data memory (slave).
interface ysyx_22040386_dmem_if;

    logic        i_DM_req_valid;
    logic        o_DM_req_ready;
    logic        i_DM_req_write;
    logic [63:0] i_DM_req_addr;
    logic [63:0] i_DM_req_wdata;
    logic [7:0]  i_DM_req_wmask;
    logic        o_DM_resp_valid;
    logic        i_DM_resp_ready;
    logic [63:0] o_DM_resp_rdata;
    logic        o_DM_resp_err;

    modport master (
        output i_DM_req_valid, i_DM_req_write, i_DM_req_addr, i_DM_req_wdata, i_DM_req_wmask,
        output i_DM_resp_ready,
        input  o_DM_req_ready, o_DM_resp_valid, o_DM_resp_rdata, o_DM_resp_err
    );

    modport slave (
        input  i_DM_req_valid, i_DM_req_write, i_DM_req_addr, i_DM_req_wdata, i_DM_req_wmask,
        input  i_DM_resp_ready,
        output o_DM_req_ready, o_DM_resp_valid, o_DM_resp_rdata, o_DM_resp_err
    );

endinterface

// File: rtl/ysyx_22040386_dmem_sram.sv
// Single-port doubleword SRAM with per-byte write enables and a registered read.
module ysyx_22040386_dmem_sram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    input  logic [7:0]    be,
    output logic [63:0]   rdata
);

    logic [63:0] mem_r [0:(1<<AW)-1];
    logic [63:0] q_r;

    // Byte-lane writes; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (en && we && be[b]) begin
                mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read port register, only updated by reads so it holds across a response.
    always_ff @(posedge clk) begin
        if (en && !we) begin
            q_r <= mem_r[idx];
        end
    end

    assign rdata = q_r;

endmodule

// File: rtl/ysyx_22040386_dmem_responder.sv
// Memory end of the MEM-stage load/store bus: one request at a time, fixed wait, then a
// response carrying the read doubleword or a write acknowledge, with an out-of-window flag.
module ysyx_22040386_dmem_responder
    import ysyx_22040386_dmem_pkg::*;
#(
    parameter int          AW        = 10,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic                      i_DM_clk,
    input  logic                      i_DM_rst_n,
    ysyx_22040386_dmem_if.slave       dm
);

    localparam logic             DIRECT_RESP = (LATENCY == 0);
    localparam logic [CNT_W-1:0] LAT_CNT     = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    dm_state_e        state_r;
    dm_state_e        state_n_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n_s;
    logic             req_ready_r;
    logic             resp_valid_r;
    logic             resp_err_r;
    logic             rd_sel_r;

    logic             wr_r;
    logic [63:0]      addr_r;
    logic [63:0]      wdata_r;
    logic [7:0]       wmask_r;

    logic             accept_s;
    logic             commit_s;
    logic             acc_write_s;
    logic [63:0]      acc_addr_s;
    logic [63:0]      acc_wdata_s;
    logic [7:0]       acc_wmask_s;
    logic             in_range_s;
    logic             borrow_s;
    logic [AW-1:0]    idx_s;
    logic             sram_en_s;
    logic [63:0]      sram_q_s;

    // Next-state logic; the SRAM access (commit) happens on the edge that enters RESP.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        accept_s  = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dm.i_DM_req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    cnt_n_s  = LAT_CNT;
                    if (DIRECT_RESP) begin
                        state_n_s = ST_RESP;
                        commit_s  = 1'b1;
                    end else begin
                        state_n_s = ST_WAIT;
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_n_s = ST_RESP;
                    commit_s  = 1'b1;
                end else begin
                    cnt_n_s = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: begin
                if (dm.i_DM_resp_ready) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_RESP;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // With zero latency the commit uses the live request, otherwise the latched copy.
    always_comb begin
        if (DIRECT_RESP) begin
            acc_write_s = dm.i_DM_req_write;
            acc_addr_s  = dm.i_DM_req_addr;
            acc_wdata_s = dm.i_DM_req_wdata;
            acc_wmask_s = dm.i_DM_req_wmask;
        end else begin
            acc_write_s = wr_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_wmask_s = wmask_r;
        end
    end

    // Doubleword index of (addr - BASE_ADDR), built from the high bits plus the low-bit borrow.
    assign in_range_s = dm_in_window(acc_addr_s, BASE_ADDR, AW);
    assign borrow_s   = (acc_addr_s[2:0] < BASE_ADDR[2:0]);
    assign idx_s      = acc_addr_s[AW+2:3] - BASE_ADDR[AW+2:3] - {{(AW-1){1'b0}}, borrow_s};
    assign sram_en_s  = commit_s && in_range_s;

    ysyx_22040386_dmem_sram #(.AW(AW)) u_sram (
        .clk   (i_DM_clk),
        .en    (sram_en_s),
        .we    (acc_write_s),
        .idx   (idx_s),
        .wdata (acc_wdata_s),
        .be    (acc_wmask_s),
        .rdata (sram_q_s)
    );

    // State, wait counter and request-ready register.
    always_ff @(posedge i_DM_clk) begin
        if (!i_DM_rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            req_ready_r <= (state_n_s == ST_IDLE);
        end
    end

    // Request capture at acceptance.
    always_ff @(posedge i_DM_clk) begin
        if (!i_DM_rst_n) begin
            wr_r    <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
            wmask_r <= 8'd0;
        end else if (accept_s) begin
            wr_r    <= dm.i_DM_req_write;
            addr_r  <= dm.i_DM_req_addr;
            wdata_r <= dm.i_DM_req_wdata;
            wmask_r <= dm.i_DM_req_wmask;
        end
    end

    // Response flags; rd_sel_r gates the SRAM read register onto rdata only for good loads.
    always_ff @(posedge i_DM_clk) begin
        if (!i_DM_rst_n) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= RESP_OK;
            rd_sel_r     <= 1'b0;
        end else if (commit_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= in_range_s ? RESP_OK : RESP_ERR;
            rd_sel_r     <= !acc_write_s && in_range_s;
        end else if ((state_r == ST_RESP) && dm.i_DM_resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= RESP_OK;
            rd_sel_r     <= 1'b0;
        end
    end

    assign dm.o_DM_req_ready  = req_ready_r;
    assign dm.o_DM_resp_valid = resp_valid_r;
    assign dm.o_DM_resp_err   = resp_err_r;
    assign dm.o_DM_resp_rdata = rd_sel_r ? sram_q_s : 64'd0;

endmodule

// File: tb/tb_ysyx_22040386_dmem_responder.sv
// Bench for the data-memory responder: transaction-level model plus directed literal checks.
module tb_ysyx_22040386_dmem_responder;

    localparam int          AW        = 10;
    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int          LAT       = 2;
    localparam logic [63:0] WIN_BYTES = 64'h2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic bp_hold = 1'b0;

    ysyx_22040386_dmem_if dm();

    ysyx_22040386_dmem_responder #(.AW(AW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .i_DM_clk   (clk),
        .i_DM_rst_n (rst_n),
        .dm         (dm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state: what the outputs must be after each clock edge.
    logic        m_ready = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [63:0] m_rdata = 64'd0;
    logic [7:0]  m_rmask = 8'hFF;
    bit          pend    = 1'b0;
    int          due     = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    logic        p_wr;
    logic [63:0] p_addr, p_wdata, p_off;
    logic [7:0]  p_wmask;
    int          p_idx;
    logic [63:0] mmem [0:1023];
    logic [7:0]  mkn  [0:1023] = '{default: 8'h00};

    function automatic logic [63:0] expand(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, updated once per rising edge from the bench-driven inputs only.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_ready = 1'b0; m_valid = 1'b0; m_err = 1'b0;
                m_rdata = 64'd0; m_rmask = 8'hFF; pend = 1'b0;
            end else begin
                if (m_valid) begin
                    if (dm.i_DM_resp_ready) begin
                        m_valid = 1'b0; m_err = 1'b0; m_rdata = 64'd0; m_rmask = 8'hFF;
                    end
                end else if (pend) begin
                    if (cyc == due) begin
                        pend = 1'b0; m_valid = 1'b1; m_rdata = 64'd0; m_rmask = 8'hFF;
                        if (p_addr >= BASE && p_addr < BASE + WIN_BYTES) begin
                            m_err = 1'b0;
                            p_off = p_addr - BASE;
                            p_idx = int'(p_off[12:3]);
                            if (p_wr) begin
                                for (int b = 0; b < 8; b++) begin
                                    if (p_wmask[b]) begin
                                        mmem[p_idx][8*b +: 8] = p_wdata[8*b +: 8];
                                        mkn[p_idx][b] = 1'b1;
                                    end
                                end
                            end else begin
                                m_rdata = mmem[p_idx] & expand(mkn[p_idx]);
                                m_rmask = mkn[p_idx];
                            end
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end else if (m_ready && dm.i_DM_req_valid) begin
                    p_wr = dm.i_DM_req_write; p_addr = dm.i_DM_req_addr;
                    p_wdata = dm.i_DM_req_wdata; p_wmask = dm.i_DM_req_wmask;
                    pend = 1'b1; due = cyc + 1 + LAT; acc_cnt++; acc_cyc = cyc;
                end
                m_ready = !pend && !m_valid;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("req_ready", {63'd0, dm.o_DM_req_ready}, {63'd0, m_ready});
                chk("resp_valid", {63'd0, dm.o_DM_resp_valid}, {63'd0, m_valid});
                chk("resp_err", {63'd0, dm.o_DM_resp_err}, {63'd0, m_err});
                chk("resp_rdata", dm.o_DM_resp_rdata & expand(m_rmask), m_rdata & expand(m_rmask));
            end
        end
    end

    // Response back-pressure: random, or held low while bp_hold is set.
    initial begin
        dm.i_DM_resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            dm.i_DM_resp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [7:0] wm, output int t_acc);
        int start;
        start = acc_cnt;
        t_acc = -1;
        dm.i_DM_req_write = wr; dm.i_DM_req_addr = a;
        dm.i_DM_req_wdata = wd; dm.i_DM_req_wmask = wm;
        dm.i_DM_req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) begin
                t_acc = acc_cyc;
                break;
            end
        end
        dm.i_DM_req_valid = 1'b0;
        dm.i_DM_req_addr  = {$urandom, $urandom};
        dm.i_DM_req_wdata = {$urandom, $urandom};
        dm.i_DM_req_wmask = 8'($urandom);
        dm.i_DM_req_write = 1'($urandom);
        n_checks++;
        if (t_acc < 0) begin
            n_fail++;
            $display("FAIL accept_timeout: request to %h not accepted within 100 cycles", a);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (!pend && !m_valid && m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: responder not idle within 200 cycles");
        end
    endtask

    // One transaction with hand-computed response, pinning both latency and payload.
    task automatic xact_check(input string name, input logic wr, input logic [63:0] a,
                              input logic [63:0] wd, input logic [7:0] wm,
                              input logic [63:0] exp_rdata, input logic exp_err);
        int t;
        send(wr, a, wd, wm, t);
        if (t >= 0) begin
            while (cyc < t + LAT) begin @(posedge clk); #1; end
            @(negedge clk);
            chk({name, "_early"}, {63'd0, dm.o_DM_resp_valid}, 64'd0);
            @(negedge clk);
            chk({name, "_valid"}, {63'd0, dm.o_DM_resp_valid}, 64'd1);
            chk({name, "_rdata"}, dm.o_DM_resp_rdata, exp_rdata);
            chk({name, "_err"}, {63'd0, dm.o_DM_resp_err}, {63'd0, exp_err});
        end
        wait_idle();
    endtask

    initial begin
        int t;
        logic [63:0] ra, rd;
        logic [7:0]  rm;
        int          sel;

        dm.i_DM_req_valid = 1'b1; dm.i_DM_req_write = 1'b1;
        dm.i_DM_req_addr  = BASE; dm.i_DM_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        dm.i_DM_req_wmask = 8'hFF;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_valid", {63'd0, dm.o_DM_resp_valid}, 64'd0);
            chk("rst_rdata", dm.o_DM_resp_rdata, 64'd0);
            chk("rst_err", {63'd0, dm.o_DM_resp_err}, 64'd0);
            chk("rst_ready", {63'd0, dm.o_DM_req_ready}, 64'd0);
        end
        rst_n = 1'b1;
        dm.i_DM_req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ready_after_rst", {63'd0, dm.o_DM_req_ready}, 64'd1);

        xact_check("st_full", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0);
        xact_check("ld_full", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);
        xact_check("st_part", 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'd0, 1'b0);
        xact_check("ld_part", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0);
        xact_check("st_top", 1'b1, 64'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0);
        xact_check("ld_oor_lo", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1);
        xact_check("st_oor_hi", 1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1);
        xact_check("ld_top", 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);
        xact_check("st_nomask", 1'b1, 64'h8000_0013, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 64'd0, 1'b0);
        xact_check("ld_unaligned", 1'b0, 64'h8000_0017, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0);

        // Held response: payload stays put and a second request is refused.
        bp_hold = 1'b1;
        send(1'b0, 64'h8000_0010, 64'd0, 8'h00, t);
        while (cyc < t + LAT + 1) begin @(posedge clk); #1; end
        dm.i_DM_req_write = 1'b0; dm.i_DM_req_addr = 64'h8000_1FF8;
        dm.i_DM_req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, dm.o_DM_resp_valid}, 64'd1);
            chk("bp_rdata", dm.o_DM_resp_rdata, 64'h1122_3344_BBBB_BBBB);
            chk("bp_ready", {63'd0, dm.o_DM_req_ready}, 64'd0);
        end
        bp_hold = 1'b0;
        send(1'b0, 64'h8000_1FF8, 64'd0, 8'h00, t);
        wait_idle();

        // Reset while a write is waiting: the write must never land.
        xact_check("st_0x20", 1'b1, 64'h8000_0020, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 64'd0, 1'b0);
        send(1'b1, 64'h8000_0020, 64'h5555_6666_7777_8888, 8'hFF, t);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle();
        xact_check("ld_after_rst", 1'b0, 64'h8000_0020, 64'd0, 8'h00, 64'hCAFE_F00D_0BAD_BEEF, 1'b0);

        repeat (80) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                ra = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
            end else if (sel == 1) begin
                ra = BASE + WIN_BYTES + 64'($urandom_range(0, 31));
            end else begin
                ra = BASE + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
            end
            sel = $urandom_range(0, 5);
            rm = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            rd = {$urandom, $urandom};
            send(1'($urandom), ra, rd, rm, t);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
